// File: rtl/trap_irq_source_if.sv
// Register bus between the CPU core and the trap/interrupt source block.
// The master drives strobes, address and write data; the slave returns registered read data.
interface trap_irq_source_if;
  logic        bus_we;
  logic        bus_re;
  logic [2:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;

  modport master (output bus_we, bus_re, bus_addr, bus_wdata, input bus_rdata);
  modport slave  (input bus_we, bus_re, bus_addr, bus_wdata, output bus_rdata);
endinterface

// File: rtl/trap_irq_source.sv
// Machine-mode interrupt source: mtime/mtimecmp timer, software MSIP, edge-latched external lines,
// and a request/in-service FSM that presents one prioritised mcause to the exception unit.
module trap_irq_source #(
  parameter int N_EXT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  trap_irq_source_if.slave     bus,
  input  logic [N_EXT-1:0]     ext_irq,
  input  logic                 mie_global,
  output logic                 irq_req,
  output logic [31:0]          irq_cause,
  input  logic                 irq_ack,
  input  logic                 mret_in
);

  typedef enum logic [1:0] {IDLE, REQ, INSVC} state_e;

  localparam logic [2:0] A_MTIME_LO    = 3'd0;
  localparam logic [2:0] A_MTIME_HI    = 3'd1;
  localparam logic [2:0] A_MTIMECMP_LO = 3'd2;
  localparam logic [2:0] A_MTIMECMP_HI = 3'd3;
  localparam logic [2:0] A_MSIP        = 3'd4;
  localparam logic [2:0] A_EXT_PEND    = 3'd5;
  localparam logic [2:0] A_EXT_EN      = 3'd6;
  localparam logic [2:0] A_SRC_EN      = 3'd7;

  localparam logic [3:0] CODE_EXT = 4'd11;
  localparam logic [3:0] CODE_SW  = 4'd3;
  localparam logic [3:0] CODE_TMR = 4'd7;

  logic [N_EXT-1:0] sync1_q, sync2_q, prev_q;
  logic [N_EXT-1:0] pend_q, pend_d, late_q, late_d, en_q, en_d;
  logic [63:0]      mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
  logic             msip_q, msip_d;
  logic [2:0]       src_en_q, src_en_d;
  logic [31:0]      rdata_q, rdata_d, rd_mux;
  state_e           state_q;
  logic             irq_req_q;
  logic [31:0]      irq_cause_q;

  logic             wr_pend;
  logic [N_EXT-1:0] rise, set_vec, clr_vec;
  logic             ext_elig, sw_elig, tmr_elig, any_elig;
  logic [3:0]       sel_code;

  assign rise    = sync2_q & ~prev_q;
  assign wr_pend = bus.bus_we && (bus.bus_addr == A_EXT_PEND);
  assign clr_vec = wr_pend ? bus.bus_wdata[N_EXT-1:0] : '0;
  // An edge that collides with a clear is parked in late_q and lands one cycle later.
  assign set_vec = rise | late_q;

  assign ext_elig = (|(pend_q & en_q)) && src_en_q[2];
  assign sw_elig  = msip_q && src_en_q[0];
  assign tmr_elig = (mtime_q >= mtimecmp_q) && src_en_q[1];
  assign any_elig = ext_elig || sw_elig || tmr_elig;
  assign sel_code = ext_elig ? CODE_EXT : (sw_elig ? CODE_SW : CODE_TMR);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    rd_mux     = '0;
    pend_d     = (pend_q | set_vec) & ~clr_vec;
    late_d     = set_vec & clr_vec;
    en_d       = en_q;
    msip_d     = msip_q;
    src_en_d   = src_en_q;
    mtimecmp_d = mtimecmp_q;
    mtime_d    = mtime_q + 64'd1;
    rdata_d    = rdata_q;

    case (bus.bus_addr)
      A_MTIME_LO:    rd_mux = mtime_q[31:0];
      A_MTIME_HI:    rd_mux = mtime_q[63:32];
      A_MTIMECMP_LO: rd_mux = mtimecmp_q[31:0];
      A_MTIMECMP_HI: rd_mux = mtimecmp_q[63:32];
      A_MSIP:        rd_mux = {31'b0, msip_q};
      A_EXT_PEND:    rd_mux[N_EXT-1:0] = pend_q;
      A_EXT_EN:      rd_mux[N_EXT-1:0] = en_q;
      A_SRC_EN:      rd_mux = {29'b0, src_en_q};
    endcase
    if (bus.bus_re) rdata_d = rd_mux;

    if (bus.bus_we) begin
      case (bus.bus_addr)
        A_MTIME_LO:    mtime_d = {mtime_q[63:32], bus.bus_wdata};
        A_MTIME_HI:    mtime_d = {bus.bus_wdata, mtime_q[31:0]};
        A_MTIMECMP_LO: mtimecmp_d[31:0]  = bus.bus_wdata;
        A_MTIMECMP_HI: mtimecmp_d[63:32] = bus.bus_wdata;
        A_MSIP:        msip_d   = bus.bus_wdata[0];
        A_EXT_EN:      en_d     = bus.bus_wdata[N_EXT-1:0];
        A_SRC_EN:      src_en_d = bus.bus_wdata[2:0];
        default:       ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      pend_q     <= '0;
      late_q     <= '0;
      en_q       <= '0;
      msip_q     <= 1'b0;
      src_en_q   <= '0;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      rdata_q    <= '0;
    end else begin
      sync1_q    <= ext_irq;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      pend_q     <= pend_d;
      late_q     <= late_d;
      en_q       <= en_d;
      msip_q     <= msip_d;
      src_en_q   <= src_en_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      rdata_q    <= rdata_d;
    end
  end

  // Once raised, a request is held until acknowledged regardless of source or mie_global.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      irq_req_q   <= 1'b0;
      irq_cause_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (mie_global && any_elig) begin
            state_q     <= REQ;
            irq_req_q   <= 1'b1;
            irq_cause_q <= {1'b1, 27'b0, sel_code};
          end
        end
        REQ: begin
          if (irq_ack) begin
            state_q   <= INSVC;
            irq_req_q <= 1'b0;
          end
        end
        INSVC: begin
          if (mret_in) begin
            state_q     <= IDLE;
            irq_cause_q <= '0;
          end
        end
        default: begin
          state_q     <= IDLE;
          irq_req_q   <= 1'b0;
          irq_cause_q <= '0;
        end
      endcase
    end
  end

  assign bus.bus_rdata = rdata_q;
  assign irq_req       = irq_req_q;
  assign irq_cause     = irq_cause_q;

endmodule
